// File: rtl/pf_pkg.sv
// Shared types and default dimensions for the playfield scroller.
package pf_pkg;
   localparam int DEF_ROWS = 8;
   localparam int DEF_COLS = 8;

   typedef logic [DEF_COLS-1:0] row_t;
   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
endpackage

// File: rtl/row_shift_reg.sv
// ROWS-deep barrier-row shift register: new rows enter at row 0 and move toward row ROWS-1.
module row_shift_reg
   import pf_pkg::*;
#(
   parameter int  ROWS     = DEF_ROWS,
   parameter type row_type = row_t
) (
   input  logic                clk,
   input  logic                clear,
   input  logic                shift_en,
   input  row_type             row_in,
   output row_type [ROWS-1:0]  grid
);

   always_ff @(posedge clk) begin
      if (clear) begin
         grid <= '0;
      end else if (shift_en) begin
         // bottom row falls off the end
         grid <= {grid[ROWS-2:0], row_in};
      end
   end

endmodule

// File: rtl/playfield_scroller.sv
// Scrolls barrier rows down the playfield, overlays the cart, detects collisions and keeps score.
module playfield_scroller
   import pf_pkg::*;
#(
   parameter int ROWS    = DEF_ROWS,
   parameter int COLS    = DEF_COLS,
   parameter int SCORE_W = 10,
   parameter int BLINK_W = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       tick,
   input  logic [COLS-1:0]            row_in,
   input  logic [2:0]                 cart_col,
   output logic [ROWS-1:0][COLS-1:0]  green,
   output logic [ROWS-1:0][COLS-1:0]  red,
   output logic                       gg,
   output logic [SCORE_W-1:0]         score
);

   state_t                     state, state_next;
   logic [ROWS-1:0][COLS-1:0]  grid;
   logic [COLS-1:0]            cart_mask;
   logic [BLINK_W-1:0]         blink;
   logic                       clear, shift_en, hit;

   assign cart_mask = COLS'(1) << cart_col;
   assign hit       = |(grid[ROWS-1] & cart_mask);
   assign green     = grid;

   row_shift_reg #(
      .ROWS     (ROWS),
      .row_type (logic [COLS-1:0])
   ) u_rows (
      .clk      (clk),
      .clear    (clear | ~reset),
      .shift_en (shift_en),
      .row_in   (row_in),
      .grid     (grid)
   );

   always_comb begin
      state_next = state;
      clear      = 1'b0;
      shift_en   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               clear      = 1'b1;
               state_next = PLAY;
            end
         end
         PLAY: begin
            // a restart request wins over a simultaneous collision
            if (start) begin
               clear = 1'b1;
            end else if (hit) begin
               state_next = OVER;
            end else if (tick) begin
               shift_en = 1'b1;
            end
         end
         OVER: begin
            if (start) begin
               clear      = 1'b1;
               state_next = PLAY;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         gg    <= 1'b0;
         score <= '0;
         blink <= '0;
      end else begin
         state <= state_next;
         gg    <= (state_next == OVER);
         if (clear) begin
            score <= '0;
         end else if (shift_en && (|grid[ROWS-1]) && (score != '1)) begin
            score <= score + 1'b1;
         end
         // blink only runs while the game is over, so it starts from zero on every loss
         blink <= (state == OVER && !start) ? blink + 1'b1 : '0;
      end
   end

   always_comb begin
      red = '0;
      if (state != OVER || !blink[BLINK_W-1]) begin
         red[ROWS-1] = cart_mask;
      end
   end

endmodule
